// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the divider issue controller:
//   - M-extension divide op encoding (low two bits of req_op, plus the W bit)
//   - controller FSM state type
//   - signedness encoding expected by the iterative divider
//   - small helpers for decoding ops and sign-extending 32-bit values
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Bit position of the W-form flag inside req_op.
    localparam int unsigned OP_W = 2;

    localparam logic [1:0] DIV_SIGNED   = 2'b11;
    localparam logic [1:0] DIV_UNSIGNED = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } div_state_e;

    // DIV/REM are signed, DIVU/REMU are unsigned.
    function automatic logic op_is_signed(input logic [1:0] func);
        return ~func[0];
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient.
    function automatic logic op_is_rem(input logic [1:0] func);
        return func[1];
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_special_chk.sv
// -----------------------------------------------------------------------------
// div_special_chk
// Combinational detection of the architectural divide special cases, which
// are resolved without running the iterative divider.
//   dividend, divisor : prepared (W-form already sign/zero-extended) operands
//   is_signed, is_w   : operation signedness and 32-bit form
//   is_div0           : divisor is zero
//   is_ovf            : signed most-negative / -1 overflow
//   spec_q, spec_r    : quotient/remainder pair for whichever case applies
//                       (divide-by-zero takes priority)
// -----------------------------------------------------------------------------
module div_special_chk
    import div_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_w,
    output logic            is_div0,
    output logic            is_ovf,
    output logic [XLEN-1:0] spec_q,
    output logic [XLEN-1:0] spec_r
);

    logic [XLEN-1:0] most_neg;

    always_comb begin
        most_neg = is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};

        is_div0  = (divisor == '0);
        // A prepared W-form -1 is all ones, so one compare covers both widths.
        is_ovf   = is_signed && (dividend == most_neg) && (divisor == '1);

        if (is_div0) begin
            spec_q = '1;
            // The remainder is the dividend reported as a sign-extended word,
            // even for REMUW whose prepared dividend is zero-extended.
            spec_r = is_w ? sext32(dividend[31:0]) : dividend;
        end else begin
            spec_q = dividend;
            spec_r = '0;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Sequencing controller between the EXU and the iterative radix-2 divider.
// Accepts RISC-V M-extension divide/remainder ops, resolves divide-by-zero and
// signed overflow locally, runs everything else through the divider with
// operands held stable, and returns the 64-bit rd value over valid/ready.
// A one-entry quotient/remainder cache lets a DIV followed by the matching
// REM (or vice versa) complete without a second divider run.
//
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   req_valid/req_ready   op request handshake
//   req_op                [2]=W-form, [1:0]=DIV/DIVU/REM/REMU
//   req_src1, req_src2    dividend, divisor
//   flush                 kill the in-flight op
//   resp_valid/resp_ready result handshake, resp_data = final rd value
//   div_valid, div_flush  divider start / abort
//   div_w, div_signed     divider mode (32-bit, 2'b11 signed / 2'b00 unsigned)
//   div_dividend/divisor  operands, held from ISSUE through WAIT
//   div_ready             divider idle
//   div_out_valid         divider result pulse with div_quotient/div_remainder
// -----------------------------------------------------------------------------
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            flush,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,

    output logic            div_valid,
    output logic            div_flush,
    output logic            div_w,
    output logic [1:0]      div_signed,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_ready,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    div_state_e      state;
    logic            issue_q;
    logic            rem_q;

    logic            req_is_w;
    logic            req_signed;
    logic            req_rem;
    logic [XLEN-1:0] prep_a;
    logic [XLEN-1:0] prep_b;
    logic            accept;

    logic            chk_div0;
    logic            chk_ovf;
    logic [XLEN-1:0] spec_q;
    logic [XLEN-1:0] spec_r;

    logic            c_valid;
    logic [XLEN-1:0] c_dividend;
    logic [XLEN-1:0] c_divisor;
    logic            c_signed;
    logic            c_w;
    logic [XLEN-1:0] c_quot;
    logic [XLEN-1:0] c_rem;
    logic            cache_hit;
    logic [XLEN-1:0] cache_val;

    logic [XLEN-1:0] fix_q;
    logic [XLEN-1:0] fix_r;

    // Request decode and operand preparation.
    always_comb begin
        req_is_w   = req_op[OP_W];
        req_signed = op_is_signed(req_op[1:0]);
        req_rem    = op_is_rem(req_op[1:0]);
        if (req_is_w) begin
            prep_a = req_signed ? sext32(req_src1[31:0]) : {32'h0, req_src1[31:0]};
            prep_b = req_signed ? sext32(req_src2[31:0]) : {32'h0, req_src2[31:0]};
        end else begin
            prep_a = req_src1;
            prep_b = req_src2;
        end
    end

    always_comb begin
        req_ready = (state == ST_IDLE) && div_ready && !flush;
        accept    = req_ready && req_valid;
        // The start pulse is registered, but a flush arriving in ISSUE must
        // still keep it from reaching the divider.
        div_valid = issue_q && !flush;
    end

    div_special_chk #(
        .XLEN (XLEN)
    ) u_special_chk (
        .dividend  (prep_a),
        .divisor   (prep_b),
        .is_signed (req_signed),
        .is_w      (req_is_w),
        .is_div0   (chk_div0),
        .is_ovf    (chk_ovf),
        .spec_q    (spec_q),
        .spec_r    (spec_r)
    );

    always_comb begin
        cache_hit = CACHE_EN && c_valid
                    && (c_dividend == prep_a) && (c_divisor == prep_b)
                    && (c_signed == req_signed) && (c_w == req_is_w);
        cache_val = req_rem ? c_rem : c_quot;
    end

    // The divider zero-extends W-form results; rd wants them sign-extended.
    always_comb begin
        fix_q = div_w ? sext32(div_quotient[31:0])  : div_quotient;
        fix_r = div_w ? sext32(div_remainder[31:0]) : div_remainder;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            issue_q      <= 1'b0;
            rem_q        <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            div_flush    <= 1'b0;
            div_w        <= 1'b0;
            div_signed   <= DIV_UNSIGNED;
            div_dividend <= '0;
            div_divisor  <= '0;
            c_valid      <= 1'b0;
            c_dividend   <= '0;
            c_divisor    <= '0;
            c_signed     <= 1'b0;
            c_w          <= 1'b0;
            c_quot       <= '0;
            c_rem        <= '0;
        end else begin
            issue_q   <= 1'b0;
            div_flush <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        div_dividend <= prep_a;
                        div_divisor  <= prep_b;
                        div_w        <= req_is_w;
                        div_signed   <= req_signed ? DIV_SIGNED : DIV_UNSIGNED;
                        rem_q        <= req_rem;
                        if (chk_div0 || chk_ovf) begin
                            resp_data  <= req_rem ? spec_r : spec_q;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else if (cache_hit) begin
                            resp_data  <= cache_val;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            issue_q <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    state <= flush ? ST_IDLE : ST_WAIT;
                end

                ST_WAIT: begin
                    if (flush) begin
                        // Flush beats a coincident result pulse: nothing is
                        // returned and the cache keeps its old contents.
                        div_flush <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (div_out_valid) begin
                        resp_data  <= rem_q ? fix_r : fix_q;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                        if (CACHE_EN) begin
                            c_valid    <= 1'b1;
                            c_dividend <= div_dividend;
                            c_divisor  <= div_divisor;
                            c_signed   <= (div_signed == DIV_SIGNED);
                            c_w        <= div_w;
                            c_quot     <= fix_q;
                            c_rem      <= fix_r;
                        end
                    end
                end

                ST_RESP: begin
                    if (flush || resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
// Bench for div_issue_ctrl with a behavioural iterative-divider model and a
// reference model built from the RISC-V divide rules (results, special cases,
// pair-cache reuse and expected latency).
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        div_valid;
    logic        div_flush;
    logic        div_w;
    logic [1:0]  div_signed;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic        div_ready;
    logic        div_out_valid;
    logic [63:0] div_quotient;
    logic [63:0] div_remainder;

    div_issue_ctrl #(
        .XLEN     (64),
        .CACHE_EN (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .div_valid     (div_valid),
        .div_flush     (div_flush),
        .div_w         (div_w),
        .div_signed    (div_signed),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_ready     (div_ready),
        .div_out_valid (div_out_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- divider model ----------------
    // Starts on div_valid, raises a one-cycle result pulse a fixed number of
    // cycles later (65 for 64-bit, 33 for W), zero-extends W results, aborts
    // on div_flush or reset.
    int          n_issue  = 0;
    int          n_dflush = 0;
    int          stab_bad = 0;
    bit          busy;
    int          cnt;
    logic [63:0] s_a, s_b;
    logic        s_w;
    logic [1:0]  s_sg;
    logic [31:0] m_a32, m_b32;

    initial begin
        div_ready     = 1'b1;
        div_out_valid = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        busy          = 1'b0;
        cnt           = 0;
        forever begin
            @(posedge clock);
            #2;
            div_out_valid = 1'b0;
            if (div_flush) n_dflush++;
            if (reset) begin
                busy      = 1'b0;
                div_ready = 1'b1;
            end else if (busy && div_flush) begin
                busy      = 1'b0;
                div_ready = 1'b1;
            end else if (busy) begin
                if (div_dividend !== s_a || div_divisor !== s_b || div_w !== s_w || div_signed !== s_sg)
                    stab_bad++;
                cnt--;
                if (cnt == 0) begin
                    busy = 1'b0;
                    div_out_valid = 1'b1;
                    if (div_w) begin
                        m_a32 = div_dividend[31:0];
                        m_b32 = div_divisor[31:0];
                        if (div_signed == 2'b11) begin
                            div_quotient  = {32'h0, 32'($signed(m_a32) / $signed(m_b32))};
                            div_remainder = {32'h0, 32'($signed(m_a32) % $signed(m_b32))};
                        end else begin
                            div_quotient  = {32'h0, m_a32 / m_b32};
                            div_remainder = {32'h0, m_a32 % m_b32};
                        end
                    end else if (div_signed == 2'b11) begin
                        div_quotient  = 64'($signed(div_dividend) / $signed(div_divisor));
                        div_remainder = 64'($signed(div_dividend) % $signed(div_divisor));
                    end else begin
                        div_quotient  = div_dividend / div_divisor;
                        div_remainder = div_dividend % div_divisor;
                    end
                end
            end else begin
                div_ready = 1'b1;
                if (div_valid) begin
                    busy      = 1'b1;
                    div_ready = 1'b0;
                    cnt       = div_w ? 33 : 65;
                    s_a       = div_dividend;
                    s_b       = div_divisor;
                    s_w       = div_w;
                    s_sg      = div_signed;
                    n_issue++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        bit          w, sgn, rem;
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] q, r;
        w   = op[2];
        sgn = !op[0];
        rem = op[1];
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 0;
            end else if (sgn) begin
                q32 = 32'($signed(a32) / $signed(b32));
                r32 = 32'($signed(a32) % $signed(b32));
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            res32 = rem ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = 0;
        end else if (sgn) begin
            q = 64'($signed(a) / $signed(b));
            r = 64'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return rem ? r : q;
    endfunction

    function automatic logic [63:0] prep(input logic [63:0] v, input bit w, input bit sgn);
        if (!w) return v;
        return sgn ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
    endfunction

    // Last completed divider run: {prepared operands, signedness, width}.
    bit          mc_valid = 1'b0;
    logic [63:0] mc_a, mc_b;
    bit          mc_s, mc_w;

    task automatic model_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output int lat);
        bit          w, sgn;
        logic [63:0] pa, pb;
        w   = op[2];
        sgn = !op[0];
        pa  = prep(a, w, sgn);
        pb  = prep(b, w, sgn);
        if (pb == 0)
            lat = 1;
        else if (sgn && pb == '1 && pa == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            lat = 1;
        else if (mc_valid && mc_a == pa && mc_b == pb && mc_s == sgn && mc_w == w)
            lat = 1;
        else begin
            mc_valid = 1'b1;
            mc_a     = pa;
            mc_b     = pb;
            mc_s     = sgn;
            mc_w     = w;
            lat      = w ? 35 : 67;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int guard;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check_eq({tag, "_acc"}, 64'(guard < 100), 64'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_data, input int hold);
        int          exp_lat, lat, iss0, bad;
        logic [63:0] held;
        model_latency(op, a, b, exp_lat);
        iss0 = n_issue;
        send_req(tag, op, a, b);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (resp_valid !== 1'b1 && lat < 200);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_data"}, resp_data, exp_data);
        check_eq({tag, "_iss"}, 64'(n_issue - iss0), (exp_lat == 1) ? 64'd0 : 64'd1);
        if (hold > 0) begin
            bad  = 0;
            held = resp_data;
            repeat (hold) begin
                @(negedge clock);
                if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0) bad++;
            end
            check_eq({tag, "_hold"}, 64'(bad), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) seen++;
        end
        check_eq({tag, "_noresp"}, 64'(seen), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [2:0]  r_op, last_op;
    logic [63:0] r_a, r_b;
    int          sel, iss0, fl0;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_src1   = '0;
        req_src2   = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        last_op    = '0;
        r_a        = '0;
        r_b        = '0;
        repeat (3) @(negedge clock);

        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_data", resp_data, 64'd0);
        check_eq("rst_div_valid", 64'(div_valid), 64'd0);
        check_eq("rst_div_flush", 64'(div_flush), 64'd0);
        check_eq("rst_div_mode", {61'd0, div_w, div_signed}, 64'd0);
        check_eq("rst_div_opnds", div_dividend | div_divisor, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Divider path then pair-cache hit.
        run_op("div100_7", 3'b000, 64'd100, 64'd7, 64'd14, 0);
        run_op("rem100_7", 3'b010, 64'd100, 64'd7, 64'd2, 0);
        // W-form signed.
        run_op("divw_m7_2", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("remw_m7_2", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        // Divide by zero.
        run_op("divu_x_0", 3'b001, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("remu_x_0", 3'b011, 64'h1234, 64'd0, 64'h1234, 0);
        // Signed overflow, 64-bit and W.
        run_op("div_ovf", 3'b000, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
        run_op("remw_ovf", 3'b110, 64'h0000_0000_8000_0000, '1, 64'd0, 0);

        // Flush while the divider is running.
        iss0 = n_issue;
        fl0  = n_dflush;
        send_req("fl_wait", 3'b000, 64'd1000, 64'd3);
        repeat (19) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        quiet_window("fl_wait", 80);
        check_eq("fl_wait_dflush", 64'(n_dflush - fl0), 64'd1);
        check_eq("fl_wait_iss", 64'(n_issue - iss0), 64'd1);
        run_op("rem1000_3", 3'b010, 64'd1000, 64'd3, 64'd1, 0);

        // Flush in ISSUE: the start pulse must never reach the divider.
        iss0 = n_issue;
        send_req("fl_issue", 3'b000, 64'd9999, 64'd7);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        quiet_window("fl_issue", 8);
        check_eq("fl_issue_iss", 64'(n_issue - iss0), 64'd0);
        check_eq("fl_issue_idle", 64'(req_ready), 64'd1);

        // Flush in RESP drops the response.
        send_req("fl_resp", 3'b001, 64'h77, 64'd0);
        @(negedge clock);
        check_eq("fl_resp_valid", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_eq("fl_resp_drop", 64'(resp_valid), 64'd0);
        check_eq("fl_resp_idle", 64'(req_ready), 64'd1);

        // Flush with a request pending in IDLE: no accept.
        iss0 = n_issue;
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_src1  = 64'd55;
        req_src2  = 64'd0;
        flush     = 1'b1;
        @(negedge clock);
        check_eq("fl_idle_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        req_valid = 1'b0;
        flush     = 1'b0;
        quiet_window("fl_idle", 4);

        // Back-pressure: result held stable for 10 cycles.
        run_op("hold", 3'b001, 64'h55, 64'd7, 64'hC, 10);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 9));
            r_op = 3'($urandom_range(0, 7));
            if (sel < 3 && i > 0) begin
                r_op = {last_op[2], ~last_op[1], last_op[0]};
            end else if (sel == 3) begin
                r_a = {$urandom, $urandom};
                r_b = r_op[2] ? {$urandom, 32'h0} : 64'h0;
            end else if (sel == 4) begin
                r_a = r_op[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                r_b = r_op[2] ? {$urandom, 32'hFFFF_FFFF} : '1;
            end else if (sel < 8) begin
                r_a = 64'($urandom_range(0, 5000));
                r_b = 64'($urandom_range(1, 60));
                if ($urandom_range(0, 1) == 1) r_a = -r_a;
                if ($urandom_range(0, 1) == 1) r_b = -r_b;
            end else begin
                r_a = {$urandom, $urandom};
                r_b = {$urandom, $urandom} >> $urandom_range(0, 60);
            end
            run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, ref_result(r_op, r_a, r_b), (sel == 9) ? 3 : 0);
            last_op = r_op;
        end

        // Reset mid-WAIT: outputs clear at once and the cache is forgotten.
        run_op("div500_9", 3'b000, 64'd500, 64'd9, 64'd55, 0);
        send_req("rst_wait", 3'b000, -64'd77, 64'd5);
        repeat (10) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstw_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rstw_resp_data", resp_data, 64'd0);
        check_eq("rstw_div_ctl", {60'd0, div_valid, div_flush, div_signed}, 64'd0);
        check_eq("rstw_div_w", 64'(div_w), 64'd0);
        check_eq("rstw_div_a", div_dividend, 64'd0);
        check_eq("rstw_div_b", div_divisor, 64'd0);
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        mc_valid = 1'b0;
        @(negedge clock);
        run_op("rem500_9", 3'b010, 64'd500, 64'd9, 64'd5, 0);

        check_eq("opnd_stable", 64'(stab_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Sequencing controller between the EXU and the iterative radix-2 divider (64/32-iteration, Idle/Busy/Valid).
- Accepts RISC-V M-extension divide/remainder ops over a valid/ready handshake.
- Resolves the architectural special cases (divide-by-zero, signed overflow) without the divider.
- Holds operands stable for the divider's whole run, captures its one-cycle result pulse, and returns a 64-bit result over valid/ready.
- Includes a one-entry quotient/remainder pair cache so a DIV followed by the matching REM (or vice versa) completes in one cycle.

Parameters:
XLEN, 64, datapath width (only 64 supported)
CACHE_EN, 1, 1 enables the quotient/remainder pair cache

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high
req_valid  in  1  op request
req_ready  out  1  controller can accept
req_op  in  3  [2]=W-form; [1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
req_src1  in  64  dividend
req_src2  in  64  divisor
flush  in  1  kill in-flight op
resp_valid  out  1  result available
resp_ready  in  1  result consumed
resp_data  out  64  final rd value
div_valid  out  1  to divider: start
div_flush  out  1  to divider: abort
div_w  out  1  to divider: 32-bit mode
div_signed  out  2  to divider: 2'b11 signed, 2'b00 unsigned
div_dividend  out  64  to divider
div_divisor  out  64  to divider
div_ready  in  1  divider idle
div_out_valid  in  1  divider result pulse
div_quotient  in  64  divider quotient
div_remainder  in  64  divider remainder

Behaviour:
- Reset (async): state IDLE; req_ready=1 iff div_ready; resp_valid=0; resp_data=0; all div_* outputs 0; cache invalid.
- Operand prep, registered at accept:
  - W-form signed: sign-extend src[31:0]. W-form unsigned: zero-extend src[31:0].
  - Prepared operands drive div_dividend/div_divisor continuously from ISSUE through WAIT. They must not change while the divider is busy.
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = div_ready & ~flush. On accept, the next state is chosen in this priority:
  - divisor == 0 → RESP. Quotient = all ones; remainder = dividend (W-form: sign-extended low 32 bits).
  - signed op, dividend == most-negative (64-bit, or 32-bit for W), divisor == −1 → RESP. Quotient = dividend; remainder = 0.
  - CACHE_EN and cache valid and {prepared dividend, divisor, signed, W} match → RESP with the cached value.
  - otherwise → ISSUE.
- ISSUE: div_valid=1 for exactly one cycle → WAIT.
- WAIT: div_valid=0. On div_out_valid, latch quotient/remainder → RESP.
  - W-form quotient/remainder are sign-extended from bit 31 (the divider zero-extends them).
  - Cache is updated with {operands, signed, W, q, r}.
- RESP: resp_valid=1 and resp_data stable until resp_ready; on handshake → IDLE. Back-to-back accept is possible the cycle after.
- Latency from req accept (cycle 0) to resp_valid:
  - divider path: 67 cycles 64-bit, 35 cycles W-form;
  - special case or cache hit: 1 cycle.
- Flush:
  - In ISSUE: suppress div_valid → IDLE.
  - In WAIT: div_flush=1 for one cycle → IDLE; results are discarded and the cache is not updated.
  - In RESP: drop resp_valid → IDLE.
  - Flush in the same cycle as div_out_valid: flush wins and the cache is not updated.
  - Flush with req_valid in IDLE: no accept.
  - Flush never invalidates existing cache contents.
- Cache invalidated only by reset.
- Unexpected div_out_valid outside WAIT is ignored.

Decomposition:
- Shared package div_ctrl_pkg: op encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_W bit), FSM state typedef, DIV_SIGNED=2'b11 / DIV_UNSIGNED=2'b00.
- One natural sub-module: div_special_chk. Combinational; takes prepared operands, signed and W; returns is_div0, is_ovf and the special q/r pair.

Test Plan:
- DIV 100 / 7 (64-bit) → resp_data=14, resp_valid 67 cycles after accept; the following REM 100/7 → 2 in 1 cycle (cache hit, div_valid not asserted).
- DIVW src1=0xFFFFFFFF_FFFFFFF9 (−7), src2=2 → resp_data=0xFFFFFFFF_FFFFFFFD (−3) after 35 cycles; REMW same operands → 0xFFFFFFFF_FFFFFFFF (−1).
- DIVU x/0 with x=0x1234 → resp_data=0xFFFFFFFF_FFFFFFFF after 1 cycle; REMU x/0 → 0x1234; div_valid never asserted.
- DIV 0x80000000_00000000 / −1 → 0x80000000_00000000; REMW 0x80000000 / −1 → 0; both in 1 cycle.
- DIV 1000/3, flush at cycle 20 → div_flush pulse, no resp_valid; next REM 1000/3 misses the cache and issues to the divider → 1.
- resp_ready held low 10 cycles → resp_valid and resp_data stable, req_ready=0; reset asserted mid-WAIT → all outputs zero immediately, divider reset alongside.
